// File: rtl/alu_arbiter_ctrl.sv
// Round-robin front end that shares one combinational 16-bit ALU between NREQ requesters.
// Each operation is accepted in IDLE, executed for one cycle, then held as a response until consumed.
module alu_arbiter_ctrl #(
  parameter int NREQ = 2,
  parameter int W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  input  logic [NREQ*4-1:0] req_op,
  output logic [W-1:0]      alu_a,
  output logic [W-1:0]      alu_b,
  output logic [3:0]        alu_op,
  input  logic [W-1:0]      alu_r,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [1:0]        rsp_id,
  output logic [W-1:0]      rsp_r,
  output logic              rsp_c,
  output logic              rsp_z,
  output logic              rsp_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic [1:0]      r_rr_ptr;
  logic [1:0]      r_id_q;

  logic            w_grant_found;
  logic [1:0]      w_grant;
  logic [NREQ-1:0] w_grant_onehot;
  logic [W-1:0]    w_sel_a;
  logic [W-1:0]    w_sel_b;
  logic [3:0]      w_sel_op;
  int              w_best;
  int              w_dist;

  logic [W-1:0]    w_res;
  logic            w_c;
  logic            w_z;
  logic            w_err;
  logic            w_carry;
  logic [1:0]      w_rr_next;

  // Winner is the valid requester at the smallest wrapped distance from the pointer.
  always_comb begin
    w_grant_found  = 1'b0;
    w_grant        = 2'd0;
    w_grant_onehot = '0;
    w_sel_a        = '0;
    w_sel_b        = '0;
    w_sel_op       = '0;
    w_best         = NREQ;
    w_dist         = 0;
    for (int i = 0; i < NREQ; i++) begin
      w_dist = i - int'(r_rr_ptr);
      if (w_dist < 0) w_dist = w_dist + NREQ;
      if (req_valid[i] && (w_dist < w_best)) begin
        w_best         = w_dist;
        w_grant_found  = 1'b1;
        w_grant        = 2'(i);
        w_grant_onehot = '0;
        w_grant_onehot[i] = 1'b1;
        w_sel_a        = req_a[i*W +: W];
        w_sel_b        = req_b[i*W +: W];
        w_sel_op       = req_op[i*4 +: 4];
      end
    end
  end

  assign w_carry   = (W'(alu_a + alu_b) < alu_a);
  assign w_rr_next = (r_id_q == 2'(NREQ - 1)) ? 2'd0 : r_id_q + 2'd1;

  // Flags come from the latched operands; the ALU only supplies the result value.
  always_comb begin
    w_res = alu_r;
    w_c   = 1'b0;
    w_z   = (alu_r == '0);
    w_err = 1'b0;
    case (alu_op)
      4'b0000: w_c = w_carry;
      4'b0001: w_c = (alu_a < alu_b);
      4'b1111: begin
        w_res = '0;
        w_c   = (alu_a < alu_b);
        w_z   = (alu_a == alu_b);
      end
      4'b0010: begin
        if (alu_b == '0) begin
          w_res = '1;
          w_err = 1'b1;
          w_z   = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_grant_found) w_next_state = EXEC;
      EXEC:    w_next_state = RESP;
      RESP:    if (rsp_ready) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    rsp_valid = 1'b0;
    case (r_state)
      IDLE:    req_ready = w_grant_onehot;
      RESP:    rsp_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr <= 2'd0;
      r_id_q   <= 2'd0;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_op   <= '0;
      rsp_r    <= '0;
      rsp_c    <= 1'b0;
      rsp_z    <= 1'b0;
      rsp_err  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant_found) begin
            alu_a  <= w_sel_a;
            alu_b  <= w_sel_b;
            alu_op <= w_sel_op;
            r_id_q <= w_grant;
          end
        end
        EXEC: begin
          rsp_r   <= w_res;
          rsp_c   <= w_c;
          rsp_z   <= w_z;
          rsp_err <= w_err;
        end
        RESP: begin
          if (rsp_ready) r_rr_ptr <= w_rr_next;
        end
        default: ;
      endcase
    end
  end

  assign rsp_id = r_id_q;

endmodule

// File: tb/tb_alu_arbiter_ctrl.sv
// Directed bench for alu_arbiter_ctrl with two requesters and a simple behavioural ALU.
module tb_alu_arbiter_ctrl;

  logic        clk;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [7:0]  req_op;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [3:0]  alu_op;
  logic [15:0] alu_r;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [15:0] rsp_r;
  logic        rsp_c;
  logic        rsp_z;
  logic        rsp_err;

  int checks = 0;
  int errors = 0;

  alu_arbiter_ctrl #(.NREQ(2), .W(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_r(alu_r),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_r(rsp_r), .rsp_c(rsp_c), .rsp_z(rsp_z), .rsp_err(rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU; op 1111 deliberately yields a nonzero difference the controller must discard.
  always_comb begin
    case (alu_op)
      4'd0:    alu_r = alu_a + alu_b;
      4'd1:    alu_r = alu_a - alu_b;
      4'd2:    alu_r = (alu_b == 16'd0) ? 16'd0 : alu_a / alu_b;
      4'd3:    alu_r = alu_a & alu_b;
      4'd4:    alu_r = alu_a | alu_b;
      4'd15:   alu_r = alu_a - alu_b;
      default: alu_r = 16'd0;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Present one request, wait (bounded) for its grant, then drop it after the accept edge.
  task automatic applyStimulus(input string tag, input logic [1:0] sel, input logic [15:0] a,
                               input logic [15:0] b, input logic [3:0] op);
    logic got;
    got = 1'b0;
    if (sel == 2'b01) begin
      req_a[15:0] = a; req_b[15:0] = b; req_op[3:0] = op;
    end else begin
      req_a[31:16] = a; req_b[31:16] = b; req_op[7:4] = op;
    end
    req_valid = req_valid | sel;
    for (int n = 0; n < 8 && !got; n++) begin
      #1;
      if ((req_ready & sel) != 2'b00) got = 1'b1;
      else tick();
    end
    checkOutput({tag, "_grant"}, 32'(got), 32'd1);
    if (got) checkOutput({tag, "_onehot"}, 32'(req_ready), 32'(sel));
    tick();
    req_valid = req_valid & ~sel;
  endtask

  task automatic waitResponse(input string tag, input logic [15:0] r, input logic c, input logic z,
                              input logic err, input logic [1:0] id);
    logic got;
    got = 1'b0;
    for (int n = 0; n < 8 && !got; n++) begin
      if (rsp_valid) got = 1'b1;
      else tick();
    end
    checkOutput({tag, "_valid"}, 32'(got), 32'd1);
    checkOutput({tag, "_r"}, 32'(rsp_r), 32'(r));
    checkOutput({tag, "_c"}, 32'(rsp_c), 32'(c));
    checkOutput({tag, "_z"}, 32'(rsp_z), 32'(z));
    checkOutput({tag, "_err"}, 32'(rsp_err), 32'(err));
    checkOutput({tag, "_id"}, 32'(rsp_id), 32'(id));
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checkOutput({tag, "_drop"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    logic [1:0] expGrant [4];
    logic [1:0] lastId;
    int         nGrant;
    int         lastCyc;

    rst = 1'b1;
    req_valid = 2'b00; req_a = '0; req_b = '0; req_op = '0; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
    checkOutput("rst_alu_a", 32'(alu_a), 32'd0);
    checkOutput("rst_alu_op", 32'(alu_op), 32'd0);
    checkOutput("rst_rsp_r", 32'(rsp_r), 32'd0);

    // Add with carry out; latency from accept to response.
    applyStimulus("add", 2'b01, 16'hFFFF, 16'h0001, 4'b0000);
    checkOutput("add_exec_valid", 32'(rsp_valid), 32'd0);
    checkOutput("add_exec_alu_a", 32'(alu_a), 32'h0000FFFF);
    checkOutput("add_exec_alu_b", 32'(alu_b), 32'h00000001);
    checkOutput("add_exec_ready", 32'(req_ready), 32'd0);
    tick();
    checkOutput("add_resp_valid", 32'(rsp_valid), 32'd1);
    waitResponse("add", 16'h0000, 1'b1, 1'b1, 1'b0, 2'd0);

    // Compare: less-than, then equal.
    applyStimulus("cmp1", 2'b10, 16'h0003, 16'h0007, 4'b1111);
    waitResponse("cmp1", 16'h0000, 1'b1, 1'b0, 1'b0, 2'd1);
    applyStimulus("cmp2", 2'b10, 16'h0007, 16'h0007, 4'b1111);
    waitResponse("cmp2", 16'h0000, 1'b0, 1'b1, 1'b0, 2'd1);

    // Fairness: both requesters held valid, consumer always ready.
    expGrant[0] = 2'b01; expGrant[1] = 2'b10; expGrant[2] = 2'b01; expGrant[3] = 2'b10;
    nGrant = 0; lastCyc = 0; lastId = 2'd0;
    req_a = {16'h0010, 16'h0001};
    req_b = {16'h0020, 16'h0001};
    req_op = 8'h00;
    req_valid = 2'b11;
    rsp_ready = 1'b1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      #1;
      if (req_ready != 2'b00 && nGrant < 4) begin
        checkOutput("fair_grant", 32'(req_ready), 32'(expGrant[nGrant]));
        if (nGrant > 0) checkOutput("fair_gap", 32'(cyc - lastCyc), 32'd3);
        lastId = (req_ready == 2'b10) ? 2'd1 : 2'd0;
        lastCyc = cyc;
        nGrant++;
      end
      if (rsp_valid) begin
        checkOutput("fair_id", 32'(rsp_id), 32'(lastId));
        checkOutput("fair_r", 32'(rsp_r), (lastId == 2'd1) ? 32'h30 : 32'h2);
      end
      tick();
    end
    req_valid = 2'b00;
    rsp_ready = 1'b0;
    checkOutput("fair_count", 32'(nGrant), 32'd4);

    // Divide by zero, then a normal divide.
    applyStimulus("div0", 2'b01, 16'h1234, 16'h0000, 4'b0010);
    waitResponse("div0", 16'hFFFF, 1'b0, 1'b0, 1'b1, 2'd0);
    applyStimulus("div", 2'b01, 16'h0064, 16'h0005, 4'b0010);
    waitResponse("div", 16'h0014, 1'b0, 1'b0, 1'b0, 2'd0);

    // Backpressure: response must hold while another requester waits.
    applyStimulus("bp", 2'b01, 16'h0003, 16'h0005, 4'b0001);
    req_a[31:16] = 16'h0001; req_b[31:16] = 16'h0001; req_op[7:4] = 4'd0;
    req_valid = 2'b10;
    tick();
    for (int n = 0; n < 5; n++) begin
      #1;
      checkOutput("bp_valid", 32'(rsp_valid), 32'd1);
      checkOutput("bp_r", 32'(rsp_r), 32'h0000FFFE);
      checkOutput("bp_c", 32'(rsp_c), 32'd1);
      checkOutput("bp_ready", 32'(req_ready), 32'd0);
      tick();
    end
    req_valid = 2'b00;
    waitResponse("bp", 16'hFFFE, 1'b1, 1'b0, 1'b0, 2'd0);

    // Reset while executing: no response, pointer back to requester 0.
    applyStimulus("rstop", 2'b10, 16'h0001, 16'h0001, 4'b0000);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("rstop_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rstop_rsp_r", 32'(rsp_r), 32'd0);
    checkOutput("rstop_alu_a", 32'(alu_a), 32'd0);
    checkOutput("rstop_id", 32'(rsp_id), 32'd0);
    repeat (2) begin
      tick();
      checkOutput("rstop_norsp", 32'(rsp_valid), 32'd0);
    end
    req_valid = 2'b11;
    #1;
    checkOutput("rstop_ptr", 32'(req_ready), 32'h1);
    req_valid = 2'b00;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
